// File: rtl/core1_pkg.sv
// core1_pkg: shared widths, reset PC and slot helpers for the core1 front end.
//   XLEN     - PC width
//   INSTR_W  - instruction width
//   TAG_W    - PC tag bits carried per slot (pc[TAG_W+1:2])
//   WIDTH    - slot width, {tag, instr}; must equal the merger's WIDTH
//   RESET_PC - first fetch address (4-byte aligned)
package core1_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned WIDTH   = TAG_W + INSTR_W;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [WIDTH-1:0]   slot_t;

  // Both slots of one fetched 64-bit word, as presented to the merger.
  typedef struct packed {
    logic  v1;
    slot_t d1;
    logic  v2;
    slot_t d2;
  } pair_t;

  function automatic slot_t pack_slot(input tag_t tag, input instr_t instr);
    return {tag, instr};
  endfunction

  function automatic tag_t slot_tag(input slot_t s);
    return s[WIDTH-1:INSTR_W];
  endfunction

  function automatic instr_t slot_instr(input slot_t s);
    return s[INSTR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry skid buffer holding a decoded slot pair while the
// downstream is stalled.
//   clk, reset - clock, synchronous active-high reset
//   flush      - drop any held entry (redirect)
//   capture    - load din (stalled cycle with a response landing)
//   pop        - release the held entry (first unstalled cycle)
//   din        - decoded pair to hold
//   full       - an entry is held
//   dout       - held pair
module fetch_skid
  import core1_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  capture,
  input  logic  pop,
  input  pair_t din,
  output logic  full,
  output pair_t dout
);

  logic  full_q;
  pair_t data_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (capture) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (pop) begin
      full_q <= 1'b0;
      data_q <= '0;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/fetch_pair.sv
// fetch_pair: instruction fetch stage feeding the two-slot merger. Fetches one
// 64-bit aligned word per unstalled cycle from a synchronous instruction memory
// and presents it as two registered, PC-tagged 32-bit slots.
//   clk, reset      - clock, synchronous active-high reset
//   stall           - downstream cannot accept; outputs hold
//   redirect_valid  - branch/jump redirect request
//   redirect_pc     - redirect target (4-byte aligned)
//   imem_req        - memory read enable (combinational)
//   imem_addr       - 8-byte aligned read address (combinational)
//   imem_rdata      - read data, valid the cycle after imem_req
//   vdout1, dout1   - lower slot (pc bit2 = 0), {pc[TAG_W+1:2], instr}
//   vdout2, dout2   - upper slot (pc bit2 = 1), {pc[TAG_W+1:2], instr}
module fetch_pair
  import core1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [63:0]      imem_rdata,
  output logic             vdout1,
  output logic [WIDTH-1:0] dout1,
  output logic             vdout2,
  output logic [WIDTH-1:0] dout2
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] sel_pc;
  logic            resp_pending;

  pair_t resp;
  pair_t out_q;
  pair_t skid_q;
  logic  skid_full;
  logic  skid_capture;
  logic  skid_pop;

  // ---------------- request side ----------------
  assign sel_pc    = redirect_valid ? redirect_pc : fetch_pc;
  assign imem_req  = !reset && (redirect_valid || !stall);
  assign imem_addr = {sel_pc[XLEN-1:3], 3'b000};

  // req_pc keeps the unaligned PC so a misaligned redirect can suppress slot1.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      resp_pending <= 1'b0;
    end else begin
      resp_pending <= imem_req;
      if (imem_req) begin
        req_pc   <= sel_pc;
        fetch_pc <= imem_addr + XLEN'(8);
      end
    end
  end

  // ---------------- response decode ----------------
  logic [TAG_W-2:0] tag_hi;
  assign tag_hi = req_pc[TAG_W+1:3];

  always_comb begin
    resp    = '0;
    resp.v1 = !req_pc[2];
    resp.d1 = resp.v1 ? pack_slot({tag_hi, 1'b0}, imem_rdata[31:0]) : '0;
    resp.v2 = 1'b1;
    resp.d2 = pack_slot({tag_hi, 1'b1}, imem_rdata[63:32]);
  end

  // ---------------- skid ----------------
  assign skid_capture = stall && resp_pending && !redirect_valid;
  assign skid_pop     = !stall && !redirect_valid && skid_full;

  fetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .capture (skid_capture),
    .pop     (skid_pop),
    .din     (resp),
    .full    (skid_full),
    .dout    (skid_q)
  );

  // ---------------- output register ----------------
  // Redirect beats stall: the response landing this cycle belongs to the old
  // stream and is dropped along with anything held in the skid.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      out_q <= '0;
    end else if (!stall) begin
      if (skid_full) begin
        out_q <= skid_q;
      end else if (resp_pending) begin
        out_q <= resp;
      end else begin
        out_q <= '0;
      end
    end
  end

  assign vdout1 = out_q.v1;
  assign dout1  = out_q.d1;
  assign vdout2 = out_q.v2;
  assign dout2  = out_q.d2;

  // Only the tag bits and bit 2 of the request PC are consumed.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_pc[XLEN-1:TAG_W+2], req_pc[1:0]};

  // No request issues while stalled, so a full skid never meets a second
  // response inside the same stall window.
  skid_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(skid_full && resp_pending && stall));

endmodule

// File: tb/tb_fetch_pair.sv
// tb_fetch_pair: directed and random stimulus for fetch_pair against a
// PC-sequence consumer model and a behavioural instruction memory.
module tb_fetch_pair;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata = '0;
  logic        vdout1;
  logic [39:0] dout1;
  logic        vdout2;
  logic [39:0] dout2;

  int checks   = 0;
  int errors   = 0;
  int consumed = 0;
  int c0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_pair dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .vdout1         (vdout1),
    .dout1          (dout1),
    .vdout2         (vdout2),
    .dout2          (dout2)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00100013;
    if (a == 32'h4) return 32'h00200093;
    return a ^ 32'hC3A5_0F01;
  endfunction

  function automatic logic [39:0] slot_of(input logic [31:0] pc);
    return {pc[9:2], instr_at(pc)};
  endfunction

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {instr_at(imem_addr + 32'd4), instr_at(imem_addr)};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply this cycle's inputs; a slot visible in an unstalled cycle is
  // consumed and must be the next PC of the current stream.
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    stall = s;
    redirect_valid = r;
    redirect_pc = rpc;
    #1;
    if (reset) begin
      exp_pc = 32'h0;
    end else begin
      if (!s) begin
        if (vdout1 === 1'b1) begin
          check("stream1", dout1, slot_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (vdout2 === 1'b1) begin
          check("stream2", dout2, slot_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
      if (r) exp_pc = rpc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic s, r;
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_pc = 32'h0;

    // reset state
    drive(0, 0, 0); check("rst_req", imem_req, 0); tick();
    drive(0, 0, 0); tick();
    check("rst_v1", vdout1, 0); check("rst_v2", vdout2, 0);
    check("rst_d1", dout1, 0);  check("rst_d2", dout2, 0);

    // 1: first fetches after reset release
    reset = 1'b0;
    drive(0, 0, 0); check("r0_req", imem_req, 1); check("r0_addr", imem_addr, 32'h0); tick();
    drive(0, 0, 0); check("r1_addr", imem_addr, 32'h8); check("r1_v1", vdout1, 0); tick();
    check("r2_v1", vdout1, 1); check("r2_v2", vdout2, 1);
    check("r2_d1", dout1, 40'h00_0010_0013); check("r2_d2", dout2, 40'h01_0020_0093);
    drive(0, 0, 0); check("r2_addr", imem_addr, 32'h10); tick();
    drive(0, 0, 0); tick();

    // 2: misaligned redirect
    drive(0, 1, 32'h44); check("rd_req", imem_req, 1); check("rd_addr", imem_addr, 32'h40); tick();
    drive(0, 0, 0); check("rd1_addr", imem_addr, 32'h48);
    check("rd1_v1", vdout1, 0); check("rd1_v2", vdout2, 0); tick();
    check("rd2_v1", vdout1, 0); check("rd2_v2", vdout2, 1);
    check("rd2_tag", dout2[39:32], 8'h11); check("rd2_d2", dout2, slot_of(32'h44));
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0); tick(); end

    // 3: three-cycle stall with a response in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      check("st_req", imem_req, 0); check("st_v1", vdout1, 1);
      check("st_d1", dout1, slot_of(exp_pc)); check("st_d2", dout2, slot_of(exp_pc + 32'd4));
      tick();
    end
    c0 = consumed;
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0); tick(); end
    check("st_count", consumed - c0, 20);

    // 4: redirect together with stall
    drive(1, 1, 32'h100); check("rs_req", imem_req, 1); check("rs_addr", imem_addr, 32'h100); tick();
    drive(1, 0, 0); check("rs1_v1", vdout1, 0); check("rs1_v2", vdout2, 0); check("rs1_req", imem_req, 0); tick();
    drive(1, 0, 0); check("rs2_v2", vdout2, 0); tick();
    drive(0, 0, 0); check("rs3_req", imem_req, 1); check("rs3_addr", imem_addr, 32'h108); check("rs3_v1", vdout1, 0); tick();
    check("rs4_v1", vdout1, 1); check("rs4_d1", dout1, {8'h40, instr_at(32'h100)});
    drive(0, 0, 0); tick();

    // address wrap-around
    drive(0, 1, 32'hFFFF_FFF8); check("wr_addr", imem_addr, 32'hFFFF_FFF8); tick();
    drive(0, 0, 0); check("wr1_addr", imem_addr, 32'h0); tick();
    check("wr2_d1", dout1, {8'hFE, instr_at(32'hFFFF_FFF8)});
    drive(0, 0, 0); tick();
    check("wr3_d1", dout1, 40'h00_0010_0013);
    drive(0, 0, 0); tick();

    // 6: reset with the skid full
    drive(0, 1, 32'h200); tick();
    drive(0, 0, 0); tick();
    drive(1, 0, 0); tick();
    reset = 1'b1;
    drive(1, 0, 0); check("mr_req", imem_req, 0); tick();
    check("mr_v1", vdout1, 0); check("mr_v2", vdout2, 0);
    drive(0, 0, 0); check("mr1_req", imem_req, 0); tick();
    reset = 1'b0;
    drive(0, 0, 0); check("mr2_req", imem_req, 1); check("mr2_addr", imem_addr, 32'h0); tick();
    drive(0, 0, 0); tick();
    check("mr4_d1", dout1, 40'h00_0010_0013);

    // 5: random stall and redirect
    c0 = consumed;
    for (int i = 0; i < 10000; i++) begin
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < 5);
      rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      drive(s, r, rpc);
      check("rnd_req", imem_req, r | !s);
      if (r) check("rnd_addr", imem_addr, {rpc[31:3], 3'b000});
      tick();
    end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0); tick(); end
    check("rnd_progress", (consumed - c0) > 2000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
